// File: rtl/frame_buf_sched_if.sv
// Writer/reader DMA handshake bundle for frame_buf_sched.
// req is a level held until the matching one-cycle start; done is a one-cycle pulse after start.
interface frame_buf_sched_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  wr_req;
  logic                  wr_start;
  logic [ADDR_WIDTH-1:0] wr_base;
  logic                  wr_done;
  logic                  rd_req;
  logic                  rd_start;
  logic [ADDR_WIDTH-1:0] rd_base;
  logic                  rd_repeat;
  logic                  rd_done;

  modport master (
    output wr_req, wr_done, rd_req, rd_done,
    input  wr_start, wr_base, rd_start, rd_base, rd_repeat
  );

  modport slave (
    input  wr_req, wr_done, rd_req, rd_done,
    output wr_start, wr_base, rd_start, rd_base, rd_repeat
  );
endinterface

// File: rtl/frame_buf_sched.sv
// Frame slot scheduler sharing FRAME_N buffers between one writer and one reader DMA.
// Define FRAME_BUF_SCHED_STAT_EN to implement the drop/repeat statistics counters.
module frame_buf_sched #(
  parameter int                    FRAME_N    = 3,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [ADDR_WIDTH-1:0] FRAME_SIZE = 32'h0010_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  frame_buf_sched_if.slave       bus,
  output logic                   proto_err,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            repeat_cnt,
  output logic [1:0]             wr_state_dbg,
  output logic [1:0]             rd_state_dbg
);
  localparam int IW = $clog2(FRAME_N);

  typedef enum logic [1:0] {S_FREE, S_WRITING, S_READY, S_READING} slot_e;
  typedef enum logic [1:0] {SIDE_IDLE, SIDE_GRANT, SIDE_BUSY} side_e;

  slot_e                 slot_q [FRAME_N];
  slot_e                 slot_d [FRAME_N];
  side_e                 wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic [IW-1:0]         wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, last_idx_q, last_idx_d;
  logic                  last_valid_q, last_valid_d;
  logic                  rd_repeat_q, rd_repeat_d;
  logic                  proto_err_q, proto_err_d;
  logic [ADDR_WIDTH-1:0] wr_base_q, wr_base_d, rd_base_q, rd_base_d;

  logic                  rd_ok, rd_rep, rd_grant;
  logic [IW-1:0]         rd_cand;
  logic                  wr_ok, wr_use_last, wr_grant;
  logic [IW-1:0]         wr_cand;
  logic                  drop_evt, rep_evt;

  function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [IW-1:0] idx);
    logic [ADDR_WIDTH-1:0] off;
    off = ADDR_WIDTH'(idx);
    return BASE_ADDR + off * FRAME_SIZE;
  endfunction

  always_comb begin
    rd_ok       = 1'b0;
    rd_rep      = 1'b0;
    rd_cand     = '0;
    wr_ok       = 1'b0;
    wr_use_last = 1'b0;
    wr_cand     = '0;
    drop_evt    = 1'b0;
    rep_evt     = 1'b0;
    slot_d       = slot_q;
    wr_st_d      = wr_st_q;
    rd_st_d      = rd_st_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    last_idx_d   = last_idx_q;
    last_valid_d = last_valid_q;
    rd_repeat_d  = rd_repeat_q;
    proto_err_d  = proto_err_q;
    wr_base_d    = wr_base_q;
    rd_base_d    = rd_base_q;

    // Reader: fresh frame first, otherwise re-show the last displayed one.
    for (int i = 0; i < FRAME_N; i++) begin
      if (slot_q[i] == S_READY) begin
        rd_ok   = 1'b1;
        rd_cand = IW'(i);
      end
    end
    if (!rd_ok && last_valid_q) begin
      rd_ok   = 1'b1;
      rd_rep  = 1'b1;
      rd_cand = last_idx_q;
    end
    rd_grant = (rd_st_q == SIDE_IDLE) && bus.rd_req && en && rd_ok;

    // Writer keeps the last displayed frame alive as long as another slot is free.
    for (int i = 0; i < FRAME_N; i++) begin
      if (!wr_ok && slot_q[i] == S_FREE
          && !(last_valid_q && IW'(i) == last_idx_q)
          && !(rd_grant && IW'(i) == rd_cand)) begin
        wr_ok   = 1'b1;
        wr_cand = IW'(i);
      end
    end
    if (!wr_ok && last_valid_q && slot_q[last_idx_q] == S_FREE
        && !(rd_grant && rd_cand == last_idx_q)) begin
      wr_ok       = 1'b1;
      wr_use_last = 1'b1;
      wr_cand     = last_idx_q;
    end
    wr_grant = (wr_st_q == SIDE_IDLE) && bus.wr_req && en && wr_ok;

    case (wr_st_q)
      SIDE_IDLE: begin
        if (bus.wr_done) proto_err_d = 1'b1;
        if (wr_grant) begin
          wr_st_d          = SIDE_GRANT;
          wr_idx_d         = wr_cand;
          wr_base_d        = slot_base(wr_cand);
          slot_d[wr_cand]  = S_WRITING;
          if (wr_use_last) last_valid_d = 1'b0;
        end
      end
      SIDE_GRANT: begin
        if (bus.wr_done) proto_err_d = 1'b1;
        wr_st_d = SIDE_BUSY;
      end
      default: if (bus.wr_done) wr_st_d = SIDE_IDLE;
    endcase

    case (rd_st_q)
      SIDE_IDLE: begin
        if (bus.rd_done) proto_err_d = 1'b1;
        if (rd_grant) begin
          rd_st_d         = SIDE_GRANT;
          rd_idx_d        = rd_cand;
          rd_base_d       = slot_base(rd_cand);
          rd_repeat_d     = rd_rep;
          rep_evt         = rd_rep;
          slot_d[rd_cand] = S_READING;
        end
      end
      SIDE_GRANT: begin
        if (bus.rd_done) proto_err_d = 1'b1;
        rd_st_d = SIDE_BUSY;
      end
      default: begin
        if (bus.rd_done) begin
          rd_st_d          = SIDE_IDLE;
          slot_d[rd_idx_q] = S_FREE;
          last_idx_d       = rd_idx_q;
          last_valid_d     = 1'b1;
        end
      end
    endcase

    // Applied after the reader grant so a READY frame taken this cycle is not dropped.
    if (wr_st_q == SIDE_BUSY && bus.wr_done) begin
      for (int i = 0; i < FRAME_N; i++) begin
        if (slot_d[i] == S_READY) begin
          slot_d[i] = S_FREE;
          drop_evt  = 1'b1;
        end
      end
      slot_d[wr_idx_q] = S_READY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRAME_N; i++) slot_q[i] <= S_FREE;
      wr_st_q      <= SIDE_IDLE;
      rd_st_q      <= SIDE_IDLE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      last_idx_q   <= '0;
      last_valid_q <= 1'b0;
      rd_repeat_q  <= 1'b0;
      proto_err_q  <= 1'b0;
      wr_base_q    <= BASE_ADDR;
      rd_base_q    <= BASE_ADDR;
    end else begin
      slot_q       <= slot_d;
      wr_st_q      <= wr_st_d;
      rd_st_q      <= rd_st_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      last_idx_q   <= last_idx_d;
      last_valid_q <= last_valid_d;
      rd_repeat_q  <= rd_repeat_d;
      proto_err_q  <= proto_err_d;
      wr_base_q    <= wr_base_d;
      rd_base_q    <= rd_base_d;
    end
  end

  assign bus.wr_start  = (wr_st_q == SIDE_GRANT);
  assign bus.rd_start  = (rd_st_q == SIDE_GRANT);
  assign bus.rd_repeat = (rd_st_q == SIDE_GRANT) && rd_repeat_q;
  assign bus.wr_base   = wr_base_q;
  assign bus.rd_base   = rd_base_q;
  assign proto_err     = proto_err_q;
  assign wr_state_dbg  = wr_st_q;
  assign rd_state_dbg  = rd_st_q;

`ifdef FRAME_BUF_SCHED_STAT_EN
  logic [15:0] drop_cnt_q, repeat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
    end else begin
      if (drop_evt && drop_cnt_q != 16'hFFFF)  drop_cnt_q   <= drop_cnt_q + 16'd1;
      if (rep_evt && repeat_cnt_q != 16'hFFFF) repeat_cnt_q <= repeat_cnt_q + 16'd1;
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign repeat_cnt = repeat_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = drop_evt ^ rep_evt;
  assign drop_cnt   = '0;
  assign repeat_cnt = '0;
`endif
endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched: a 3-slot instance (a) and a 2-slot instance (b).
module tb_frame_buf_sched;
  localparam int AW = 32;
  localparam logic [31:0] S0 = 32'h1000_0000;
  localparam logic [31:0] S1 = 32'h1010_0000;
  localparam logic [31:0] S2 = 32'h1020_0000;
`ifdef FRAME_BUF_SCHED_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  frame_buf_sched_if #(.ADDR_WIDTH(AW)) ia ();
  frame_buf_sched_if #(.ADDR_WIDTH(AW)) ib ();

  logic        proto_a, proto_b;
  logic [15:0] drop_a, rep_a, drop_b, rep_b;
  logic [1:0]  wst_a, rst_a, wst_b, rst_b;

  frame_buf_sched #(.FRAME_N(3), .ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bus(ia.slave), .proto_err(proto_a),
    .drop_cnt(drop_a), .repeat_cnt(rep_a), .wr_state_dbg(wst_a), .rd_state_dbg(rst_a)
  );

  frame_buf_sched #(.FRAME_N(2), .ADDR_WIDTH(AW)) dut_b (
    .clk(clk), .rst(rst), .en(en), .bus(ib.slave), .proto_err(proto_b),
    .drop_cnt(drop_b), .repeat_cnt(rep_b), .wr_state_dbg(wst_b), .rd_state_dbg(rst_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int v);
    return STAT ? 32'(v) : 32'd0;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    en  = 1'b1;
    ia.wr_req = 0; ia.wr_done = 0; ia.rd_req = 0; ia.rd_done = 0;
    ib.wr_req = 0; ib.wr_done = 0; ib.rd_req = 0; ib.rd_done = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_start", ia.wr_start, 0);
    check("rst_rd_start", ia.rd_start, 0);
    check("rst_wr_base", ia.wr_base, S0);
    check("rst_rd_base", ia.rd_base, S0);
    check("rst_proto", proto_a, 0);
    check("rst_drop", drop_a, 0);
    rst = 1'b0;
    step();

    // Basic write then read of slot 0
    ia.wr_req = 1; step();
    check("t1_wr_start", ia.wr_start, 1);
    check("t1_wr_base", ia.wr_base, S0);
    ia.wr_req = 0; step();
    check("t1_wr_start_pulse", ia.wr_start, 0);
    ia.wr_done = 1; step(); ia.wr_done = 0;
    ia.rd_req = 1; step();
    check("t1_rd_start", ia.rd_start, 1);
    check("t1_rd_base", ia.rd_base, S0);
    check("t1_rd_repeat", ia.rd_repeat, 0);
    ia.rd_req = 0; step();

    // Writer completes slots 1 and 2 while slot 0 is read: slot 1 is dropped
    ia.wr_req = 1; step();
    check("t2_wr_base1", ia.wr_base, S1);
    ia.wr_req = 0; step();
    ia.wr_done = 1; step(); ia.wr_done = 0;
    ia.wr_req = 1; step();
    check("t2_wr_base2", ia.wr_base, S2);
    ia.wr_req = 0; step();
    ia.wr_done = 1; step(); ia.wr_done = 0;
    check("t2_drop_cnt", drop_a, stat(1));
    ia.wr_req = 1; step();
    check("t2_wr_start3", ia.wr_start, 1);
    check("t2_wr_base3", ia.wr_base, S1);
    ia.wr_req = 0; step();

    // Reader finishes slot 0, takes READY slot 2, then repeats it
    ia.rd_done = 1; step(); ia.rd_done = 0;
    ia.rd_req = 1; step();
    check("t3_rd_start", ia.rd_start, 1);
    check("t3_rd_base", ia.rd_base, S2);
    check("t3_rd_repeat0", ia.rd_repeat, 0);
    ia.rd_req = 0; step();
    ia.rd_done = 1; step(); ia.rd_done = 0;
    ia.rd_req = 1; step();
    check("t3_rep_start", ia.rd_start, 1);
    check("t3_rep_base", ia.rd_base, S2);
    check("t3_rep_flag", ia.rd_repeat, 1);
    check("t3_repeat_cnt", rep_a, stat(1));
    ia.rd_req = 0; step();
    ia.rd_done = 1; step(); ia.rd_done = 0;
    ia.rd_req = 1; step();
    check("t3_rep2_flag", ia.rd_repeat, 1);
    check("t3_repeat_cnt2", rep_a, stat(2));
    ia.rd_req = 0; step();
    check("t3_wr_busy", wst_a, 2);
    check("t3_rd_busy", rst_a, 2);

    // Two-slot instance: writer blocked while one slot READING and one READY
    ib.wr_req = 1; step();
    check("t4_wr_base0", ib.wr_base, S0);
    ib.wr_req = 0; step();
    ib.wr_done = 1; step(); ib.wr_done = 0;
    ib.rd_req = 1; step();
    check("t4_rd_base0", ib.rd_base, S0);
    ib.rd_req = 0; step();
    ib.wr_req = 1; step();
    check("t4_wr_base1", ib.wr_base, S1);
    ib.wr_req = 0; step();
    ib.wr_done = 1; step(); ib.wr_done = 0;
    ib.wr_req = 1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ib.wr_start) seen = 1;
    end
    check("t4_blocked", seen, 0);
    ib.rd_done = 1; step(); ib.rd_done = 0;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      if (!seen) begin
        step();
        if (ib.wr_start) seen = 1;
      end
    end
    check("t4_unblocked", seen, 1);
    check("t4_wr_base_last", ib.wr_base, S0);
    ib.wr_req = 0; step();
    ib.rd_req = 1; step();
    check("t4_rd_start", ib.rd_start, 1);
    check("t4_rd_base1", ib.rd_base, S1);
    check("t4_rd_repeat", ib.rd_repeat, 0);
    ib.rd_req = 0; step();

    // Asynchronous reset with both sides of instance a busy
    #2 rst = 1'b1;
    #1;
    check("t6_wr_base", ia.wr_base, S0);
    check("t6_rd_base", ia.rd_base, S0);
    check("t6_rep_cnt", rep_a, 0);
    check("t6_wr_state", wst_a, 0);
    check("t6_rd_state", rst_a, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    ia.wr_req = 1; step();
    check("t6_wr_start", ia.wr_start, 1);
    check("t6_wr_slot0", ia.wr_base, S0);
    ia.wr_req = 0; step();

    // wr_done coincides with rd_req: grant waits one cycle
    ia.wr_done = 1; ia.rd_req = 1; step(); ia.wr_done = 0;
    check("t5_no_rd_start", ia.rd_start, 0);
    step();
    check("t5_rd_start", ia.rd_start, 1);
    check("t5_rd_base", ia.rd_base, S0);
    check("t5_rd_repeat", ia.rd_repeat, 0);
    ia.rd_req = 0; step();
    check("t5_proto_clear", proto_a, 0);
    ia.wr_done = 1; step(); ia.wr_done = 0;
    check("t5_proto_set", proto_a, 1);
    step(5);
    check("t5_proto_sticky", proto_a, 1);

    // en=0 holds off grants
    en = 1'b0;
    ia.wr_req = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ia.wr_start) seen = 1;
    end
    check("en0_no_grant", seen, 0);
    en = 1'b1; step();
    check("en1_grant", ia.wr_start, 1);
    check("en1_base", ia.wr_base, S1);
    ia.wr_req = 0; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
